chn_arb: RTL and testbench

CHN_ARB -- requirements
Module: chn_arb

---
 rtl/dma_arb_pkg.sv | 18 +
 rtl/rr_pick16.sv | 36 +++
 rtl/chn_arb.sv | 132 +++++++++++++
 tb/tb_chn_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared definitions for the DMA channel arbiter: state encoding, channel geometry
// and the default beat quota.
package dma_arb_pkg;

  localparam int NUM_CHN        = 16;
  localparam int PRI_W          = 2;
  localparam int CHN_IDX_W      = 4;
  localparam int BEAT_CNT_W     = 5;
  localparam int BEAT_QUOTA_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2,
    ST_RELS  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick16.sv
// Masked round-robin find-first: returns the first set candidate at or above ptr,
// wrapping from channel 15 back to channel 0.
module rr_pick16
  import dma_arb_pkg::*;
(
  input  logic [NUM_CHN-1:0]   cand_mask,
  input  logic [CHN_IDX_W-1:0] ptr,
  output logic [NUM_CHN-1:0]   win_onehot,
  output logic [CHN_IDX_W-1:0] win_idx
);

  logic [2*NUM_CHN-1:0] dbl_mask;
  logic [NUM_CHN-1:0]   rot_mask;
  logic [CHN_IDX_W-1:0] off;
  logic                 found;

  // Rotating the doubled mask puts the pointer position at bit 0, so the
  // wrap-around search becomes a plain lowest-set-bit search.
  assign dbl_mask = {cand_mask, cand_mask};
  assign rot_mask = dbl_mask[ptr +: NUM_CHN];

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = 0; i < NUM_CHN; i++) begin
      if (!found && rot_mask[i]) begin
        found = 1'b1;
        off   = CHN_IDX_W'(i);
      end
    end
  end

  assign win_idx    = ptr + off;
  assign win_onehot = found ? (16'h0001 << win_idx) : '0;

endmodule

// File: rtl/chn_arb.sv
// Sixteen-channel DMA bus arbiter: priority-then-round-robin selection, bounded
// beat bursts per grant, and a one-cycle release gap before the next arbitration.
module chn_arb
  import dma_arb_pkg::*;
#(
  parameter int BEAT_QUOTA = BEAT_QUOTA_DEF
) (
  input  logic                     hclk,
  input  logic                     hrst,
  input  logic                     gbc_chnc_dmacen,
  input  logic [NUM_CHN-1:0]       chn_req,
  input  logic [NUM_CHN*PRI_W-1:0] chn_pri,
  input  logic                     hready,
  output logic [NUM_CHN-1:0]       busy_chn_code,
  output logic                     arb_bmux_trgvld,
  output logic                     arb_bmux_transvld,
  output logic [NUM_CHN-1:0]       chn_beat_ack,
  output logic                     arb_grant_done
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEAT_QUOTA - 1);

  arb_state_e             state_q;
  logic [NUM_CHN-1:0]     busy_q;
  logic [CHN_IDX_W-1:0]   rr_ptr_q;
  logic [BEAT_CNT_W-1:0]  beat_cnt_q;
  logic                   trgvld_q;
  logic                   transvld_q;
  logic                   done_q;

  logic [PRI_W-1:0]       pri_arr [NUM_CHN];
  logic [PRI_W-1:0]       max_pri;
  logic [NUM_CHN-1:0]     cand_mask;
  logic [NUM_CHN-1:0]     win_onehot;
  logic [CHN_IDX_W-1:0]   win_idx;
  logic                   req_g;
  logic                   beat;
  logic                   xfer_exit;

  for (genvar gi = 0; gi < NUM_CHN; gi++) begin : g_pri
    assign pri_arr[gi] = chn_pri[gi*PRI_W +: PRI_W];
  end

  always_comb begin
    max_pri = '0;
    for (int n = 0; n < NUM_CHN; n++) begin
      if (chn_req[n] && (pri_arr[n] > max_pri)) begin
        max_pri = pri_arr[n];
      end
    end
  end

  // Only requesters sitting at the highest requested level take part in the
  // round-robin search.
  for (genvar gi = 0; gi < NUM_CHN; gi++) begin : g_cand
    assign cand_mask[gi] = chn_req[gi] & (pri_arr[gi] == max_pri);
  end

  rr_pick16 u_pick (
    .cand_mask  (cand_mask),
    .ptr        (rr_ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  assign req_g     = |(chn_req & busy_q);
  assign beat      = (state_q == ST_XFER) & hready & transvld_q;
  assign xfer_exit = (beat & (beat_cnt_q == LAST_BEAT)) | ~req_g | ~gbc_chnc_dmacen;

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q    <= ST_IDLE;
      busy_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      trgvld_q   <= 1'b0;
      transvld_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gbc_chnc_dmacen && (|chn_req)) begin
            busy_q   <= win_onehot;
            rr_ptr_q <= win_idx + 4'd1;
            trgvld_q <= 1'b1;
            state_q  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!gbc_chnc_dmacen) begin
            trgvld_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_IDLE;
          end else if (hready) begin
            beat_cnt_q <= '0;
            transvld_q <= req_g & gbc_chnc_dmacen;
            state_q    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (beat) begin
            beat_cnt_q <= beat_cnt_q + 5'd1;
          end
          if (xfer_exit) begin
            trgvld_q   <= 1'b0;
            transvld_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= ST_RELS;
          end else begin
            transvld_q <= req_g & gbc_chnc_dmacen;
          end
        end
        ST_RELS: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // busy_q is left untouched outside the IDLE load so the bus mux can finish
  // the data phase of the last beat.
  assign busy_chn_code     = busy_q;
  assign arb_bmux_trgvld   = trgvld_q;
  assign arb_bmux_transvld = transvld_q;
  assign arb_grant_done    = done_q;
  assign chn_beat_ack      = beat ? busy_q : '0;

endmodule

// File: tb/tb_chn_arb.sv
// Self-checking bench for chn_arb: directed scenarios plus random traffic, checked
// against a transaction-level reference model through an event scoreboard.
module tb_chn_arb;

  localparam int QUOTA = 4;

  localparam int PH_WAIT = 0;
  localparam int PH_OWN  = 1;
  localparam int PH_MOVE = 2;
  localparam int PH_GAP  = 3;

  localparam int EV_GRANT = 0;
  localparam int EV_BEAT  = 1;
  localparam int EV_DONE  = 2;

  logic        hclk;
  logic        hrst;
  logic        dmacen;
  logic [15:0] chn_req;
  logic [31:0] chn_pri;
  logic        hready;
  logic [15:0] busy_chn_code;
  logic        trgvld;
  logic        transvld;
  logic [15:0] chn_beat_ack;
  logic        grant_done;

  chn_arb #(.BEAT_QUOTA(QUOTA)) dut (
    .hclk              (hclk),
    .hrst              (hrst),
    .gbc_chnc_dmacen   (dmacen),
    .chn_req           (chn_req),
    .chn_pri           (chn_pri),
    .hready            (hready),
    .busy_chn_code     (busy_chn_code),
    .arb_bmux_trgvld   (trgvld),
    .arb_bmux_transvld (transvld),
    .chn_beat_ack      (chn_beat_ack),
    .arb_grant_done    (grant_done)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  typedef struct {
    int kind;
    int chn;
    int stamp;
  } ev_t;

  ev_t evq[$];
  int  grant_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_ack = 0;
  int last_done_cyc = -1;

  // Reference model: where the bus ownership stands at the start of the cycle.
  int m_phase = PH_WAIT;
  int m_gch = -1;
  int m_ptr = 0;
  int m_beats = 0;
  bit m_tv = 1'b0;
  bit m_done = 1'b0;
  bit m_known = 1'b0;

  bit          e_chk = 1'b0;
  logic [15:0] e_busy;
  logic        e_trg;
  logic        e_tv;
  logic [15:0] e_ack;
  logic        e_done;

  function automatic int onehot_idx(input logic [15:0] v);
    int idx = -1;
    int cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (v[i] === 1'b1) begin
        idx = i;
        cnt++;
      end
    end
    return (cnt == 1) ? idx : -1;
  endfunction

  function automatic void push_ev(input int kind, input int chn, input int stamp);
    ev_t e;
    e.kind  = kind;
    e.chn   = chn;
    e.stamp = stamp;
    evq.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, predict what the DUT shows during this cycle, then
  // advance the model to the next cycle.
  task automatic step(input bit en, input logic [15:0] req, input logic [31:0] pri,
                      input bit rdy, input bit rst);
    bit beat;
    int best;
    int c;
    @(posedge hclk);
    #1;
    hrst    = rst;
    dmacen  = en;
    chn_req = req;
    chn_pri = pri;
    hready  = rdy;
    cyc++;

    e_chk  = m_known;
    e_busy = (m_gch < 0) ? 16'h0 : (16'h1 << m_gch);
    e_trg  = (m_phase == PH_OWN) || (m_phase == PH_MOVE);
    e_tv   = (m_phase == PH_MOVE) && m_tv;
    beat   = e_tv && rdy;
    e_ack  = beat ? e_busy : 16'h0;
    e_done = m_done;
    m_done = 1'b0;
    if (beat) push_ev(EV_BEAT, m_gch, cyc);

    if (rst) begin
      m_phase = PH_WAIT;
      m_gch   = -1;
      m_ptr   = 0;
      m_beats = 0;
      m_tv    = 1'b0;
      m_known = 1'b1;
    end else begin
      case (m_phase)
        PH_WAIT: begin
          if (en && (req != 16'h0)) begin
            best = -1;
            for (int p = 3; p >= 0 && best < 0; p--) begin
              for (int off = 0; off < 16 && best < 0; off++) begin
                c = (m_ptr + off) % 16;
                if (req[c] && (pri[2*c +: 2] == p)) best = c;
              end
            end
            m_gch   = best;
            m_ptr   = (best + 1) % 16;
            m_phase = PH_OWN;
            push_ev(EV_GRANT, m_gch, cyc + 1);
          end
        end
        PH_OWN: begin
          if (!en) begin
            m_phase = PH_WAIT;
            m_done  = 1'b1;
            push_ev(EV_DONE, m_gch, cyc + 1);
          end else if (rdy) begin
            m_phase = PH_MOVE;
            m_beats = 0;
            m_tv    = req[m_gch];
          end
        end
        PH_MOVE: begin
          if (beat) m_beats++;
          if ((beat && m_beats == QUOTA) || !req[m_gch] || !en) begin
            m_phase = PH_GAP;
            m_tv    = 1'b0;
            m_done  = 1'b1;
            push_ev(EV_DONE, m_gch, cyc + 1);
          end else begin
            m_tv = 1'b1;
          end
        end
        default: m_phase = PH_WAIT;
      endcase
    end
  endtask

  task automatic check_event(input int kind, input int chn);
    ev_t e;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      $display("FAIL event cyc=%0d: got kind=%0d chn=%0d, expected none", cyc, kind, chn);
    end else begin
      e = evq.pop_front();
      if (e.kind != kind || e.chn != chn || e.stamp != cyc) begin
        errors++;
        $display("FAIL event cyc=%0d: got kind=%0d chn=%0d, expected kind=%0d chn=%0d cyc=%0d",
                 cyc, kind, chn, e.kind, e.chn, e.stamp);
      end
    end
  endtask

  // Monitor: compares every observable cycle and pops scoreboard events as the
  // DUT presents grants, beat acks and release pulses.
  initial begin : monitor
    logic prev_trg;
    ev_t  stale;
    prev_trg = 1'b0;
    forever begin
      @(negedge hclk);
      if (e_chk) begin
        while (evq.size() > 0 && evq[0].stamp < cyc) begin
          stale = evq.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_event: got nothing, expected kind=%0d chn=%0d cyc=%0d",
                   stale.kind, stale.chn, stale.stamp);
        end
        checks++;
        if ({busy_chn_code, trgvld, transvld, chn_beat_ack, grant_done} !==
            {e_busy, e_trg, e_tv, e_ack, e_done}) begin
          errors++;
          $display("FAIL outputs cyc=%0d: got busy=%h trg=%b tv=%b ack=%h done=%b, expected busy=%h trg=%b tv=%b ack=%h done=%b",
                   cyc, busy_chn_code, trgvld, transvld, chn_beat_ack, grant_done,
                   e_busy, e_trg, e_tv, e_ack, e_done);
        end
        if (trgvld === 1'b1 && prev_trg !== 1'b1) begin
          check_event(EV_GRANT, onehot_idx(busy_chn_code));
          grant_log.push_back(onehot_idx(busy_chn_code));
        end
        if (chn_beat_ack !== 16'h0) begin
          check_event(EV_BEAT, onehot_idx(chn_beat_ack));
          n_ack++;
        end
        if (grant_done === 1'b1) begin
          check_event(EV_DONE, onehot_idx(busy_chn_code));
          last_done_cyc = cyc;
        end
      end
      prev_trg = trgvld;
    end
  end

  task automatic idle(input int n);
    repeat (n) step(1'b1, 16'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1'b1, 16'h0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin : driver
    int t0;
    int a0;
    int g0;
    logic [15:0] rq;
    logic [31:0] pr;

    hrst = 1'b1; dmacen = 1'b0; chn_req = 16'h0; chn_pri = 32'h0; hready = 1'b0;

    // Reset values.
    do_reset(3);
    idle(1);
    @(negedge hclk); #1;
    chk("rst_busy", 32'(busy_chn_code), 32'h0);
    chk("rst_trgvld", 32'(trgvld), 32'h0);
    chk("rst_transvld", 32'(transvld), 32'h0);
    chk("rst_ack", 32'(chn_beat_ack), 32'h0);
    chk("rst_done", 32'(grant_done), 32'h0);

    // Single request on channel 2: 7 cycles from request to IDLE.
    t0 = cyc + 1; a0 = n_ack; g0 = grant_log.size();
    repeat (7) step(1'b1, 16'h0004, 32'h0, 1'b1, 1'b0);
    idle(3);
    @(negedge hclk); #1;
    chk("single_acks", 32'(n_ack - a0), 32'd4);
    chk("single_done_ofs", 32'(last_done_cyc - t0), 32'd6);
    chk("single_grant", 32'(grant_log[g0]), 32'd2);
    chk("single_busy_hold", 32'(busy_chn_code), 32'h0004);

    // Priority: ch9 at pri 3 beats ch1 at pri 1.
    g0 = grant_log.size();
    repeat (6) step(1'b1, 16'h0202, 32'h000C_0004, 1'b1, 1'b0);
    repeat (8) step(1'b1, 16'h0002, 32'h000C_0004, 1'b1, 1'b0);
    idle(3);
    chk("prio_first", 32'(grant_log[g0]), 32'd9);
    chk("prio_second", 32'(grant_log[g0 + 1]), 32'd1);

    // Round-robin from a fresh pointer.
    do_reset(2);
    g0 = grant_log.size();
    repeat (28) step(1'b1, 16'h1021, 32'h0, 1'b1, 1'b0);
    idle(3);
    chk("rr_0", 32'(grant_log[g0]), 32'd0);
    chk("rr_1", 32'(grant_log[g0 + 1]), 32'd5);
    chk("rr_2", 32'(grant_log[g0 + 2]), 32'd12);
    chk("rr_3", 32'(grant_log[g0 + 3]), 32'd0);

    // Early drop of ch3 after two beats.
    a0 = n_ack;
    repeat (4) step(1'b1, 16'h0008, 32'h0, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 32'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 32'h0, 1'b1, 1'b0);
    @(negedge hclk); #1;
    chk("drop_transvld", 32'(transvld), 32'h0);
    chk("drop_done", 32'(grant_done), 32'h1);
    idle(3);
    @(negedge hclk); #1;
    chk("drop_acks", 32'(n_ack - a0), 32'd2);
    chk("drop_busy_hold", 32'(busy_chn_code), 32'h0008);

    // hready stalls inside XFER.
    t0 = cyc + 1; a0 = n_ack;
    repeat (3) step(1'b1, 16'h0040, 32'h0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 16'h0040, 32'h0, 1'b0, 1'b0);
    repeat (4) step(1'b1, 16'h0040, 32'h0, 1'b1, 1'b0);
    idle(3);
    chk("stall_acks", 32'(n_ack - a0), 32'd4);
    chk("stall_done_ofs", 32'(last_done_cyc - t0), 32'd9);

    // DMA disabled during GRANT.
    t0 = cyc + 1; a0 = n_ack;
    step(1'b1, 16'h0080, 32'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0080, 32'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 32'h0, 1'b1, 1'b0);
    idle(3);
    chk("dis_acks", 32'(n_ack - a0), 32'd0);
    chk("dis_done_ofs", 32'(last_done_cyc - t0), 32'd2);

    // Reset in the middle of XFER after two beats.
    repeat (4) step(1'b1, 16'h0400, 32'h0, 1'b1, 1'b0);
    step(1'b1, 16'h0400, 32'h0, 1'b0, 1'b1);
    step(1'b1, 16'h0000, 32'h0, 1'b0, 1'b0);
    @(negedge hclk); #1;
    chk("mrst_busy", 32'(busy_chn_code), 32'h0);
    chk("mrst_trgvld", 32'(trgvld), 32'h0);
    chk("mrst_transvld", 32'(transvld), 32'h0);
    chk("mrst_ack", 32'(chn_beat_ack), 32'h0);
    chk("mrst_done", 32'(grant_done), 32'h0);
    g0 = grant_log.size();
    step(1'b1, 16'h8001, 32'h0, 1'b1, 1'b0);
    idle(5);
    chk("mrst_ptr_zero", 32'(grant_log[g0]), 32'd0);

    // Random traffic against the model.
    rq = 16'h0;
    pr = $urandom;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(15) == 0) rq[b] = ~rq[b];
      end
      if ($urandom_range(31) == 0) pr = $urandom;
      step($urandom_range(31) != 0, rq, pr, $urandom_range(3) != 0, $urandom_range(499) == 0);
    end
    idle(8);
    @(negedge hclk); #1;
    chk("queue_empty", 32'(evq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
